diffeq_arbiter: RTL and testbench
=================================

DIFFEQ_ARBITER -- requirements
Module: diffeq_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter W, default 32: operand/result width.
REQ-003 Parameter TIMEOUT, default 1023: max WAIT cycles before abort (used only with DIFFEQ_ARB_TIMEOUT_EN).
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester job request.
REQ-007 req_ready  out  NREQ  one-hot accept strobe; at most one bit high per cycle.
REQ-008 req_x/req_y/req_u/req_a/req_dx  in  NREQ*W each  flattened operands; requester i at bits [i*W +: W].
REQ-009 sol_start  out  1  one-cycle start pulse to the shared diffeq solver.
REQ-010 sol_x/sol_y/sol_u/sol_a/sol_dx  out  W each  registered operands, stable from sol_start until the job ends.
REQ-011 sol_done  in  1  one-cycle solver completion pulse.
REQ-012 sol_xout/sol_yout/sol_uout  in  W each  solver results, valid with sol_done.
REQ-013 sol_abort  out  1  one-cycle abort pulse to solver.
REQ-014 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-015 rsp_id  out  clog2(NREQ)  requester index of the job.
REQ-016 rsp_x/rsp_y/rsp_u  out  W each  result; rsp_err  out  1  job timed out.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; exactly one job in flight.
REQ-018 IDLE: if any req_valid, grant round-robin from (last_grant+1) mod NREQ; assert req_ready[g] that cycle, latch req_*[g] into sol_*, record rsp_id=g, go ISSUE.
REQ-019 ISSUE: sol_start=1 for exactly one cycle, go WAIT; a sol_done seen in ISSUE is ignored.
REQ-020 WAIT: on sol_done latch sol_xout/yout/uout into rsp_x/y/u, rsp_err=0, go RESP.
REQ-021 RESP: rsp_valid held high with stable rsp_* until rsp_ready=1; on that cycle go IDLE and set last_grant=rsp_id.
REQ-022 Latency: accept at cycle T -> sol_start at T+1; sol_done at cycle D -> rsp_valid at D+1.
REQ-023 Requests are not accepted in ISSUE/WAIT/RESP; req_ready stays 0 and requester holds req_valid.
REQ-024 Minimum turnaround: next accept no earlier than the cycle after rsp handshake.
REQ-025 Operands pass through unmodified; no arithmetic on data, widths exactly W.

Reset
REQ-026 reset low: state=IDLE, last_grant=NREQ-1 (requester 0 wins first), req_ready=0, sol_start=0, sol_abort=0, rsp_valid=0, rsp_err=0, rsp_id=0, all data registers 0.
REQ-027 Reset mid-job discards the job without response; solver is not pulsed.

Configuration
REQ-028 Macro DIFFEQ_ARB_TIMEOUT_EN defined: WAIT counter cleared on entry; if TIMEOUT cycles elapse with no sol_done, pulse sol_abort one cycle, load rsp_x/y/u from sol_x/y/u, rsp_err=1, go RESP; sol_done on the same cycle as expiry wins (normal result, no abort).
REQ-029 Macro undefined: no counter, WAIT is unbounded, sol_abort and rsp_err tied 0.

Structure
REQ-030 Package diffeq_pkg holds W default, state enum type, and the requester-index width constant/function.
REQ-031 One sub-module diffeq_rr_arbiter: combinational round-robin pick (req vector, last_grant -> grant index, any).

Verification
REQ-032 Single req: req_valid[2]=1, x=0,y=1,u=1,a=5,dx=1 -> req_ready[2] same cycle, sol_start next cycle with those operands; sol_done(xout=5,yout=7,uout=9) -> rsp_valid next cycle, rsp_id=2, rsp={5,7,9}.
REQ-033 All four requesting continuously, immediate sol_done, rsp_ready=1 -> grants 0,1,2,3,0 in order.
REQ-034 rsp_ready held 0 for 10 cycles -> rsp_* stable, no new req_ready until handshake.
REQ-035 reset asserted in WAIT -> all outputs at reset values asynchronously; next request to requester 1 and 0 simultaneously grants 0.
REQ-036 DIFFEQ_ARB_TIMEOUT_EN, TIMEOUT=8, no sol_done -> sol_abort pulse 8 cycles after WAIT entry, rsp_err=1, rsp = original operands; sol_done on expiry cycle -> rsp_err=0, no abort.

Source files
------------

// File: rtl/diffeq_pkg.sv
// Shared types and constants for the diffeq job arbiter.
// Optional timeout feature macro: DIFFEQ_ARB_TIMEOUT_EN.
package diffeq_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester-index width; never below 1 bit so a 2-requester build still works.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/diffeq_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant.
module diffeq_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  grant,
  output logic            any
);

  logic [IDW-1:0] idx;

  // First requester found after last_grant (wrapping) wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/diffeq_arbiter.sv
// Arbitrates NREQ requesters onto one shared diffeq solver, one job at a time.
// Valid/ready: a transfer happens on a rising CLK edge where valid and ready
// are both high; req_valid is held by the requester until req_ready, and
// rsp_* stay stable while rsp_valid is high and rsp_ready is low.
// Optional macro DIFFEQ_ARB_TIMEOUT_EN adds a WAIT timeout with solver abort.
module diffeq_arbiter
  import diffeq_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = W_DEFAULT,
  parameter int TIMEOUT = 1023,
  localparam int IDW    = idx_w(NREQ)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_u,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_dx,
  output logic              sol_start,
  output logic [W-1:0]      sol_x,
  output logic [W-1:0]      sol_y,
  output logic [W-1:0]      sol_u,
  output logic [W-1:0]      sol_a,
  output logic [W-1:0]      sol_dx,
  input  logic              sol_done,
  input  logic [W-1:0]      sol_xout,
  input  logic [W-1:0]      sol_yout,
  input  logic [W-1:0]      sol_uout,
  output logic              sol_abort,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_x,
  output logic [W-1:0]      rsp_y,
  output logic [W-1:0]      rsp_u,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] gnt;
  logic           any;

  diffeq_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (gnt),
    .any        (any)
  );

  assign dbg_state = state;

  // Accept strobe is same-cycle; gated by reset so nothing is accepted while held in reset.
  assign req_ready = (reset && (state == ST_IDLE) && any) ? (NREQ'(1) << gnt) : '0;

`ifdef DIFFEQ_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign sol_abort      = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  // Job FSM: grant, pulse start, wait for done (or timeout), hold response.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NREQ - 1);
      sol_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      sol_x      <= '0;
      sol_y      <= '0;
      sol_u      <= '0;
      sol_a      <= '0;
      sol_dx     <= '0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_u      <= '0;
`ifdef DIFFEQ_ARB_TIMEOUT_EN
      sol_abort  <= 1'b0;
      rsp_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      sol_start <= 1'b0;
`ifdef DIFFEQ_ARB_TIMEOUT_EN
      sol_abort <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (any) begin
            sol_x     <= req_x[int'(gnt)*W +: W];
            sol_y     <= req_y[int'(gnt)*W +: W];
            sol_u     <= req_u[int'(gnt)*W +: W];
            sol_a     <= req_a[int'(gnt)*W +: W];
            sol_dx    <= req_dx[int'(gnt)*W +: W];
            rsp_id    <= gnt;
            sol_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // sol_done here is deliberately ignored: the solver has not started yet.
          state <= ST_WAIT;
`ifdef DIFFEQ_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (sol_done) begin
            rsp_x     <= sol_xout;
            rsp_y     <= sol_yout;
            rsp_u     <= sol_uout;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
`ifdef DIFFEQ_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
          end
`ifdef DIFFEQ_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Timed out: return the original operands flagged as an error.
            sol_abort <= 1'b1;
            rsp_x     <= sol_x;
            rsp_y     <= sol_y;
            rsp_u     <= sol_u;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            last_grant <= rsp_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diffeq_arbiter.sv
// Self-checking bench for diffeq_arbiter (NREQ=4, W=32, TIMEOUT=8).
module tb_diffeq_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 8;
  localparam int RW      = 2 + 3*W + 1;

  logic              CLK;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x, req_y, req_u, req_a, req_dx;
  logic              sol_start;
  logic [W-1:0]      sol_x, sol_y, sol_u, sol_a, sol_dx;
  logic              sol_done;
  logic [W-1:0]      sol_xout, sol_yout, sol_uout;
  logic              sol_abort;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_x, rsp_y, rsp_u;
  logic              rsp_err;
  logic [1:0]        dbg_state;

  diffeq_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_u(req_u), .req_a(req_a), .req_dx(req_dx),
    .sol_start(sol_start),
    .sol_x(sol_x), .sol_y(sol_y), .sol_u(sol_u), .sol_a(sol_a), .sol_dx(sol_dx),
    .sol_done(sol_done),
    .sol_xout(sol_xout), .sol_yout(sol_yout), .sol_uout(sol_uout),
    .sol_abort(sol_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_u(rsp_u), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cur_id;
  logic [W-1:0] op_x[NREQ], op_y[NREQ], op_u[NREQ], op_a[NREQ], op_dx[NREQ];
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [3:0] mask;
    int         exp_g;
  } vec_t;
  vec_t tbl[12];

  // ---------------- scoreboard / checks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     dbg_state, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_sol_start"}, sol_start, 0);
    check({tag, "_sol_abort"}, sol_abort, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"},   rsp_err, 0);
    check({tag, "_rsp_id"},    rsp_id, 0);
    check({tag, "_sol_ops"},   {sol_x, sol_y, sol_u}, 0);
    check({tag, "_sol_ad"},    {sol_a, sol_dx}, 0);
    check({tag, "_rsp_data"},  {rsp_x, rsp_y, rsp_u}, 0);
  endtask

  // ---------------- drivers ----------------
  // Present a request in IDLE, check the same-cycle grant, return just after the accept edge.
  task automatic accept(input logic [3:0] mask, input int exp_g, input bit rnd);
    @(posedge CLK); #1;
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        op_x[i] = $urandom; op_y[i] = $urandom; op_u[i] = $urandom;
        op_a[i] = $urandom; op_dx[i] = $urandom;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W]  = op_x[i];
      req_y[i*W +: W]  = op_y[i];
      req_u[i*W +: W]  = op_u[i];
      req_a[i*W +: W]  = op_a[i];
      req_dx[i*W +: W] = op_dx[i];
    end
    req_valid = mask;
    @(negedge CLK);
    check("grant", req_ready, 128'(4'b0001 << exp_g));
    cur_id = exp_g;
    @(posedge CLK); #1;
    req_valid = '0;
  endtask

  // Called right after accept: checks start pulse/operands, returns result, handshakes.
  task automatic finish_job(input bit done_in_issue, input logic [W-1:0] xo,
                            input logic [W-1:0] yo, input logic [W-1:0] uo, input int stall);
    logic [RW-1:0] exp;
    if (done_in_issue) begin
      sol_done = 1'b1; sol_xout = ~xo; sol_yout = ~yo; sol_uout = ~uo;
    end
    @(negedge CLK);
    check("sol_start", sol_start, 1);
    check("sol_xyu", {sol_x, sol_y, sol_u}, {op_x[cur_id], op_y[cur_id], op_u[cur_id]});
    check("sol_adx", {sol_a, sol_dx}, {op_a[cur_id], op_dx[cur_id]});
    @(posedge CLK); #1;
    sol_done = 1'b1; sol_xout = xo; sol_yout = yo; sol_uout = uo;
    exp_q.push_back({2'(cur_id), xo, yo, uo, 1'b0});
    @(negedge CLK);
    check("start_pulse", sol_start, 0);
    check("rsp_early", rsp_valid, 0);
    @(posedge CLK); #1;
    sol_done = 1'b0;
    @(negedge CLK);
    check("rsp_valid", rsp_valid, 1);
    exp = exp_q.pop_front();
    check("rsp", {rsp_id, rsp_x, rsp_y, rsp_u, rsp_err}, exp);
    if (stall > 0) begin
      req_valid = '1;
      for (int i = 0; i < stall; i++) begin
        @(negedge CLK);
        check("stall_rsp", {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_u, rsp_err}, {1'b1, exp});
        check("stall_no_grant", req_ready, 0);
      end
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    @(negedge CLK);
    check("rsp_drop", rsp_valid, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};
    tbl[5]  = '{4'b1010, 1};
    tbl[6]  = '{4'b1010, 3};
    tbl[7]  = '{4'b1001, 0};
    tbl[8]  = '{4'b1001, 3};
    tbl[9]  = '{4'b0100, 2};
    tbl[10] = '{4'b0011, 0};
    tbl[11] = '{4'b1000, 3};

    for (int i = 0; i < NREQ; i++) begin
      op_x[i] = '0; op_y[i] = '0; op_u[i] = '0; op_a[i] = '0; op_dx[i] = '0;
    end
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0; sol_done = 1'b0;
    req_x = '0; req_y = '0; req_u = '0; req_a = '0; req_dx = '0;
    sol_xout = '0; sol_yout = '0; sol_uout = '0;

    // Reset state, with requests present to confirm nothing is accepted.
    repeat (2) @(posedge CLK);
    #1 req_valid = '1;
    @(negedge CLK);
    check_reset_outputs("reset");
    req_valid = '0;
    reset = 1'b1;

    // Single requester 2 with fixed operands; a stray done during ISSUE is ignored.
    op_x[2] = 32'd0; op_y[2] = 32'd1; op_u[2] = 32'd1; op_a[2] = 32'd5; op_dx[2] = 32'd1;
    accept(4'b0100, 2, 1'b0);
    finish_job(1'b1, 32'd5, 32'd7, 32'd9, 0);

    // Fresh reset so requester 0 wins first again, then the round-robin table.
    @(posedge CLK); #1 reset = 1'b0;
    #2 reset = 1'b1;
    for (int r = 0; r < 12; r++) begin
      accept(tbl[r].mask, tbl[r].exp_g, 1'b1);
      finish_job(1'b0, $urandom, $urandom, $urandom, 0);
    end

    // Response back-pressure for 10 cycles.
    accept(4'b0100, 2, 1'b1);
    finish_job(1'b0, $urandom, $urandom, $urandom, 10);

    // Reset while in WAIT discards the job; afterwards 0 beats 1.
    accept(4'b0010, 1, 1'b1);
    @(posedge CLK); #1;
    check("pre_reset_wait", dbg_state, 2);
    #2 reset = 1'b0;
    req_valid = '1;
    #1;
    check_reset_outputs("midjob");
    req_valid = '0;
    reset = 1'b1;
    accept(4'b0011, 0, 1'b1);
    finish_job(1'b0, $urandom, $urandom, $urandom, 0);

`ifdef DIFFEQ_ARB_TIMEOUT_EN
    // Timeout with no done: abort 8 cycles after WAIT entry, operands echoed.
    accept(4'b0001, 0, 1'b1);
    @(posedge CLK); #1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge CLK);
      check("to_no_abort", sol_abort, 0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("to_abort", sol_abort, 1);
    check("to_rsp", {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_u, rsp_err},
          {1'b1, 2'd0, op_x[0], op_y[0], op_u[0], 1'b1});
    rsp_ready = 1'b1;
    @(posedge CLK); #1 rsp_ready = 1'b0;
    @(negedge CLK);
    check("to_abort_pulse", sol_abort, 0);

    // Done on the expiry cycle wins.
    accept(4'b0001, 0, 1'b1);
    @(posedge CLK); #1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(negedge CLK);
      check("tie_no_abort", sol_abort, 0);
      @(posedge CLK); #1;
    end
    sol_done = 1'b1; sol_xout = 32'h1111; sol_yout = 32'h2222; sol_uout = 32'h3333;
    @(negedge CLK);
    check("tie_no_abort_last", sol_abort, 0);
    @(posedge CLK); #1 sol_done = 1'b0;
    @(negedge CLK);
    check("tie_abort", sol_abort, 0);
    check("tie_rsp", {rsp_valid, rsp_id, rsp_x, rsp_y, rsp_u, rsp_err},
          {1'b1, 2'd0, 32'h1111, 32'h2222, 32'h3333, 1'b0});
    rsp_ready = 1'b1;
    @(posedge CLK); #1 rsp_ready = 1'b0;
`endif

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
